// File: rtl/hdr_ddr_frame_ctrl_if.sv
// Handshake bundle between the HDR engine / serdes and the DDR frame controller.
interface hdr_ddr_frame_ctrl_if;
  logic        i_ddrmode_en;
  logic        i_rnw;
  logic [3:0]  i_word_cnt;
  logic        i_tx_done;
  logic        i_rx_done;
  logic        o_tx_en;
  logic        o_rx_en;
  logic [2:0]  o_tx_mode;
  logic [2:0]  o_rx_mode;
  logic        o_regf_rd_en;
  logic [11:0] o_regf_addr;
  logic [3:0]  o_word_idx;
  logic        o_ddr_mode_done;

  modport slave (
    input  i_ddrmode_en, i_rnw, i_word_cnt, i_tx_done, i_rx_done,
    output o_tx_en, o_rx_en, o_tx_mode, o_rx_mode, o_regf_rd_en,
           o_regf_addr, o_word_idx, o_ddr_mode_done
  );

  modport master (
    output i_ddrmode_en, i_rnw, i_word_cnt, i_tx_done, i_rx_done,
    input  o_tx_en, o_rx_en, o_tx_mode, o_rx_mode, o_regf_rd_en,
           o_regf_addr, o_word_idx, o_ddr_mode_done
  );
endinterface

// File: rtl/hdr_ddr_frame_ctrl.sv
// HDR-DDR frame sequencer: command preamble/word, data preamble/words, CRC, done.
module hdr_ddr_frame_ctrl #(
  parameter logic [11:0] DESC_ADDR = 12'd1000,
  parameter logic [11:0] DATA_BASE = 12'd0
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  hdr_ddr_frame_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, CMD_PRE, CMD_WORD, DATA_PRE, DATA_WORD, CRC, DONE
  } state_t;

  localparam logic [2:0] MODE_CMD_PRE  = 3'd0;
  localparam logic [2:0] MODE_CMD_WORD = 3'd1;
  localparam logic [2:0] MODE_DATA_PRE = 3'd2;
  localparam logic [2:0] MODE_DATA     = 3'd3;
  localparam logic [2:0] MODE_CRC      = 3'd4;

  state_t      state_q, state_d;
  logic        rnw_q, rnw_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        phase_done;

  logic        tx_en_q, tx_en_d;
  logic        rx_en_q, rx_en_d;
  logic [2:0]  tx_mode_q, tx_mode_d;
  logic [2:0]  rx_mode_q, rx_mode_d;
  logic        rd_en_q, rd_en_d;
  logic [11:0] addr_q, addr_d;
  logic        done_q, done_d;

  // Data and CRC phases of a read frame complete on the deserializer pulse.
  always_comb begin
    phase_done = bus.i_tx_done;
    if ((state_q == DATA_WORD || state_q == CRC) && rnw_q)
      phase_done = bus.i_rx_done;
  end

  always_comb begin
    state_d = state_q;
    rnw_d   = rnw_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (bus.i_ddrmode_en) begin
        state_d = CMD_PRE;
        rnw_d   = bus.i_rnw;
        cnt_d   = bus.i_word_cnt;
        idx_d   = 4'd0;
      end
      CMD_PRE:  if (phase_done) state_d = CMD_WORD;
      CMD_WORD: if (phase_done) state_d = (cnt_q != 4'd0) ? DATA_PRE : CRC;
      DATA_PRE: if (phase_done) state_d = DATA_WORD;
      DATA_WORD: if (phase_done) begin
        if (idx_q < cnt_q - 4'd1) idx_d = idx_q + 4'd1;
        else                      state_d = CRC;
      end
      CRC: if (phase_done) begin
        state_d = DONE;
        idx_d   = 4'd0;
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
      default: state_d = IDLE;
    endcase
    // Enable dropping mid-frame wins over any done pulse in the same cycle.
    if (state_q != IDLE && !bus.i_ddrmode_en) begin
      state_d = IDLE;
      idx_d   = 4'd0;
    end
  end

  // Outputs are decoded from the next state so they register on the entry edge.
  always_comb begin
    tx_en_d   = 1'b0;
    rx_en_d   = 1'b0;
    tx_mode_d = 3'd0;
    rx_mode_d = 3'd0;
    rd_en_d   = 1'b0;
    addr_d    = 12'd0;
    done_d    = 1'b0;
    case (state_d)
      CMD_PRE: begin
        tx_en_d   = 1'b1;
        tx_mode_d = MODE_CMD_PRE;
      end
      CMD_WORD: begin
        tx_en_d   = 1'b1;
        tx_mode_d = MODE_CMD_WORD;
        rd_en_d   = 1'b1;
        addr_d    = DESC_ADDR;
      end
      DATA_PRE: begin
        tx_en_d   = 1'b1;
        tx_mode_d = MODE_DATA_PRE;
      end
      DATA_WORD: begin
        if (rnw_d) begin
          rx_en_d   = 1'b1;
          rx_mode_d = MODE_DATA;
        end else begin
          tx_en_d   = 1'b1;
          tx_mode_d = MODE_DATA;
          rd_en_d   = 1'b1;
          addr_d    = DATA_BASE + {8'd0, idx_d};
        end
      end
      CRC: begin
        if (rnw_d) begin
          rx_en_d   = 1'b1;
          rx_mode_d = MODE_CRC;
        end else begin
          tx_en_d   = 1'b1;
          tx_mode_d = MODE_CRC;
        end
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q   <= IDLE;
      rnw_q     <= 1'b0;
      cnt_q     <= 4'd0;
      idx_q     <= 4'd0;
      tx_en_q   <= 1'b0;
      rx_en_q   <= 1'b0;
      tx_mode_q <= 3'd0;
      rx_mode_q <= 3'd0;
      rd_en_q   <= 1'b0;
      addr_q    <= 12'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rnw_q     <= rnw_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tx_en_q   <= tx_en_d;
      rx_en_q   <= rx_en_d;
      tx_mode_q <= tx_mode_d;
      rx_mode_q <= rx_mode_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_tx_en         = tx_en_q;
  assign bus.o_rx_en         = rx_en_q;
  assign bus.o_tx_mode       = tx_mode_q;
  assign bus.o_rx_mode       = rx_mode_q;
  assign bus.o_regf_rd_en    = rd_en_q;
  assign bus.o_regf_addr     = addr_q;
  assign bus.o_word_idx      = idx_q;
  assign bus.o_ddr_mode_done = done_q;

endmodule

// File: doc/hdr_ddr_frame_ctrl.md
HDR_DDR_FRAME_CTRL -- requirements
Module: hdr_ddr_frame_ctrl

Interface
REQ-001 SHALL have parameter DESC_ADDR, default 12'd1000, register-file address of the command descriptor word.
REQ-002 SHALL have parameter DATA_BASE, default 12'd0, register-file address of the first data word.
REQ-003 SHALL have i_sys_clk  input  1  system clock; every flop rises on it.
REQ-004 SHALL have i_sys_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have i_ddrmode_en  input  1  level enable from the HDR engine; one frame per enable.
REQ-006 SHALL have i_rnw  input  1  frame direction, sampled at frame start: 1 = read, 0 = write.
REQ-007 SHALL have i_word_cnt  input  4  data-word count, sampled at frame start.
REQ-008 SHALL have i_tx_done  input  1  one-cycle pulse; the serializer finished the current phase.
REQ-009 SHALL have i_rx_done  input  1  one-cycle pulse; the deserializer finished the current phase.
REQ-010 SHALL have o_tx_en  output  1  serializer enable.
REQ-011 SHALL have o_rx_en  output  1  deserializer enable.
REQ-012 SHALL have o_tx_mode  output  3  serializer phase code: 0 cmd-preamble, 1 cmd-word, 2 data-preamble, 3 data-word, 4 crc-word.
REQ-013 SHALL have o_rx_mode  output  3  deserializer phase code, using the o_tx_mode encoding.
REQ-014 SHALL have o_regf_rd_en  output  1  register-file read strobe.
REQ-015 SHALL have o_regf_addr  output  12  register-file address.
REQ-016 SHALL have o_word_idx  output  4  index of the current data word.
REQ-017 SHALL have o_ddr_mode_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-018 SHALL implement the states IDLE, CMD_PRE, CMD_WORD, DATA_PRE, DATA_WORD, CRC, and DONE.
REQ-019 SHALL, in IDLE with i_ddrmode_en=1, latch i_rnw and i_word_cnt and enter CMD_PRE on the next edge.
REQ-020 SHALL, in CMD_PRE, assert o_tx_en=1 and o_tx_mode=0, and advance to CMD_WORD on i_tx_done.
REQ-021 SHALL, in CMD_WORD, assert o_tx_mode=1, o_regf_rd_en=1 and o_regf_addr=DESC_ADDR, and advance on i_tx_done: to DATA_PRE if the latched count is nonzero, otherwise to CRC.
REQ-022 SHALL, in DATA_PRE, assert o_tx_en=1 and o_tx_mode=2 in both directions, and advance to DATA_WORD on i_tx_done.
REQ-023 SHALL, in DATA_WORD for a write frame, assert o_tx_en=1, o_tx_mode=3, o_regf_rd_en=1 and o_regf_addr=DATA_BASE+o_word_idx.
REQ-024 SHALL, in DATA_WORD for a read frame, assert o_tx_en=0, o_rx_en=1 and o_rx_mode=3, with the done event being i_rx_done.
REQ-025 SHALL, on each DATA_WORD done event, increment o_word_idx if o_word_idx < count-1 and remain in DATA_WORD, otherwise go to CRC.
REQ-026 SHALL, in CRC, assert o_tx_en=1 with o_tx_mode=4 for a write frame, or o_rx_en=1 with o_rx_mode=4 for a read frame, and go to DONE on the matching done pulse.
REQ-027 SHALL, in DONE, assert o_ddr_mode_done for exactly one cycle, deassert all enables, clear o_word_idx, and return to IDLE.
REQ-028 SHALL begin a new frame from IDLE only after i_ddrmode_en is re-sampled high, so that no done pulse is lost.
REQ-029 SHALL ignore a done pulse that arrives in a state where that pulse is not the expected event (an rx pulse in a tx phase, or any pulse in IDLE or DONE).
REQ-030 SHALL, if i_ddrmode_en falls in any non-IDLE state, go to IDLE on the next edge, clear all outputs, and not pulse o_ddr_mode_done.
REQ-031 SHALL, if i_ddrmode_en falls in the same cycle as a done pulse, give the abort priority.
REQ-032 SHALL keep the address sum DATA_BASE+o_word_idx 12 bits wide, wrapping modulo 4096.
REQ-033 SHALL drive o_regf_rd_en=0 and o_regf_addr=0 in every state other than CMD_WORD and write-frame DATA_WORD.
REQ-034 SHALL register all outputs.
REQ-035 SHALL produce a state's outputs in the cycle after the transition into that state.
REQ-036 SHALL ignore changes to i_rnw and i_word_cnt during a frame.

Reset
REQ-037 SHALL, on i_sys_rst_n=0, immediately force state IDLE and all outputs to 0, including o_word_idx, o_ddr_mode_done and o_regf_addr.
REQ-038 SHALL, on reset asserted mid-frame, discard the frame with no done pulse, and start the next frame only after reset release and a sampled i_ddrmode_en=1.

Verification
REQ-039 SHALL cover a write frame with count=2: enable, then tx_done pulses → o_tx_mode sequence 0,1,2,3,3,4; o_regf_addr 1000, then 0, then 1; exactly one o_ddr_mode_done pulse after the 6th tx_done.
REQ-040 SHALL cover a read frame with count=3: tx_done×3, then rx_done×4 → o_rx_en high during data and CRC, o_rx_mode 3,3,3,4, o_word_idx 0→2, o_regf_rd_en low during data, one done pulse.
REQ-041 SHALL cover count=0: CMD_WORD tx_done → o_tx_mode goes 1→4 directly, DATA_PRE is never entered, done follows the CRC tx_done.
REQ-042 SHALL cover abort: i_ddrmode_en dropped in DATA_WORD with idx=1, coincident with tx_done → IDLE next cycle, all outputs 0, no done pulse.
REQ-043 SHALL cover async reset pulsed mid-CRC → outputs 0 immediately, with no clock edge needed; a new frame after release starts at o_tx_mode=0.
REQ-044 SHALL cover wrap-around: DATA_BASE=12'hFFF, count=2 → o_regf_addr FFF then 000.
